gpr_mp: RTL and testbench



---
 rtl/gpr_pkg.sv | 17 +
 rtl/gpr_wsel.sv | 28 ++
 rtl/gpr_mp.sv | 126 ++++++++++++
 tb/tb_gpr_mp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared register-file types and default sizes.
// Reused by decode and the hazard unit.
package gpr_pkg;

  localparam int GPR_W     = 32;
  localparam int GPR_DEPTH = 32;

  typedef enum logic {
    INIT,
    RUN
  } gpr_state_e;

  function automatic int gpr_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/gpr_wsel.sv
// Priority selector over all write ports.
// Ports: addr, wa/we/wdata (all write ports) in; hit, data out.
module gpr_wsel #(
  parameter int W  = 32,
  parameter int AW = 5,
  parameter int NW = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW-1:0]    we,
  input  logic [NW*W-1:0]  wdata,
  output logic             hit,
  output logic [W-1:0]     data
);

  // Later ports overwrite earlier ones: highest index wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NW; p++) begin
      if (we[p] && (wa[p*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wdata[p*W +: W];
      end
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port GPR file with forwarding and clear sweep.
// Ports: clk, rst, ra/rdata (NR lanes), wa/wdata/we (NW), ready, wconf.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter  int W        = GPR_W,
  parameter  int DEPTH    = GPR_DEPTH,
  parameter  int NR       = 2,
  parameter  int NW       = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = gpr_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*W-1:0]  rdata,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*W-1:0]  wdata,
  input  logic [NW-1:0]    we,
  output logic             ready,
  output logic             wconf
);

  gpr_state_e    state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [W-1:0]  mem [DEPTH];

  logic          run;
  logic [NW-1:0] we_run;
  logic [NW-1:0] w_hit;
  logic [NW-1:0] w_zero;
  logic [NW*W-1:0] w_data;
  logic          conf;

  assign run    = (state == RUN);
  assign ready  = run;
  assign we_run = we & {NW{run}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
      wconf <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      wconf <= conf;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    if (state == INIT) begin
      idx_n = idx + 1'b1;
      if (idx == AW'(DEPTH - 1)) begin
        state_n = RUN;
      end
    end
  end

  // Each port writes the winning data for its own address,
  // so colliding ports all store the same value.
  for (genvar p = 0; p < NW; p++) begin : g_wport
    assign w_zero[p] = (ZERO_REG != 0) &&
                       (wa[p*AW +: AW] == '0);

    gpr_wsel #(.W(W), .AW(AW), .NW(NW)) u_wsel (
      .addr  (wa[p*AW +: AW]),
      .wa    (wa),
      .we    (we_run),
      .wdata (wdata),
      .hit   (w_hit[p]),
      .data  (w_data[p*W +: W])
    );
  end

  always_comb begin
    conf = 1'b0;
    for (int p = 0; p < NW; p++) begin
      for (int q = p + 1; q < NW; q++) begin
        if (we_run[p] && we_run[q] && !w_zero[p] &&
            (wa[p*AW +: AW] == wa[q*AW +: AW])) begin
          conf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[idx] <= '0;
      end else begin
        for (int p = 0; p < NW; p++) begin
          if (w_hit[p] && !w_zero[p]) begin
            mem[wa[p*AW +: AW]] <= w_data[p*W +: W];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rport
    logic [AW-1:0] a;
    logic          f_hit;
    logic [W-1:0]  f_data;
    logic          zr;

    assign a  = ra[i*AW +: AW];
    assign zr = (ZERO_REG != 0) && (a == '0);

    gpr_wsel #(.W(W), .AW(AW), .NW(NW)) u_fwd (
      .addr  (a),
      .wa    (wa),
      .we    (we_run),
      .wdata (wdata),
      .hit   (f_hit),
      .data  (f_data)
    );

    assign rdata[i*W +: W] = (zr || !run) ? '0 :
                             f_hit ? f_data : mem[a];
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Directed bench for gpr_mp across several configurations.
// Table vectors plus hand sequences for sweep and reset.
module tb_gpr_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a: default parameters
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        a_we;
  logic        a_rdy, a_wc;

  gpr_mp u_a (
    .clk(clk), .rst(rst), .ra(a_ra), .rdata(a_rd),
    .wa(a_wa), .wdata(a_wd), .we(a_we),
    .ready(a_rdy), .wconf(a_wc)
  );

  // Instance b: two write ports
  logic [9:0]  b_ra;
  logic [63:0] b_rd;
  logic [9:0]  b_wa;
  logic [63:0] b_wd;
  logic [1:0]  b_we;
  logic        b_rdy, b_wc;

  gpr_mp #(.NW(2)) u_b (
    .clk(clk), .rst(rst), .ra(b_ra), .rdata(b_rd),
    .wa(b_wa), .wdata(b_wd), .we(b_we),
    .ready(b_rdy), .wconf(b_wc)
  );

  // Instance c: small, wide-read, no zero register
  logic [11:0] c_ra;
  logic [63:0] c_rd;
  logic [2:0]  c_wa;
  logic [15:0] c_wd;
  logic        c_we;
  logic        c_rdy, c_wc;

  gpr_mp #(.W(16), .DEPTH(8), .NR(4), .ZERO_REG(0)) u_c (
    .clk(clk), .rst(rst), .ra(c_ra), .rdata(c_rd),
    .wa(c_wa), .wdata(c_wd), .we(c_we),
    .ready(c_rdy), .wconf(c_wc)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] exp;
  } va_t;

  typedef struct {
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] exp;
    logic        conf;
  } vb_t;

  va_t va[8];
  vb_t vb[10];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {we, wa, wd, {ra1,ra0}, {exp1,exp0}}
    va[0] = '{1'b0, 5'd0,  32'h0,        {5'd0,  5'd5},
              {32'h0,        32'h0}};
    va[1] = '{1'b1, 5'd3,  32'hDEADBEEF, {5'd0,  5'd3},
              {32'h0,        32'hDEADBEEF}};
    va[2] = '{1'b0, 5'd0,  32'h0,        {5'd3,  5'd3},
              {32'hDEADBEEF, 32'hDEADBEEF}};
    va[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, {5'd3,  5'd0},
              {32'hDEADBEEF, 32'h0}};
    va[4] = '{1'b0, 5'd0,  32'h0,        {5'd3,  5'd0},
              {32'hDEADBEEF, 32'h0}};
    va[5] = '{1'b1, 5'd31, 32'h12345678, {5'd30, 5'd31},
              {32'h0,        32'h12345678}};
    va[6] = '{1'b1, 5'd3,  32'hA5A5A5A5, {5'd31, 5'd3},
              {32'h12345678, 32'hA5A5A5A5}};
    va[7] = '{1'b0, 5'd0,  32'h0,        {5'd5,  5'd3},
              {32'h0,        32'hA5A5A5A5}};

    // {we, {wa1,wa0}, {wd1,wd0}, {ra1,ra0}, {exp1,exp0}, wconf}
    vb[0] = '{2'b11, {5'd7, 5'd7}, {32'h22, 32'h11},
              {5'd0, 5'd7}, {32'h0,  32'h22}, 1'b0};
    vb[1] = '{2'b00, {5'd0, 5'd0}, {32'h0,  32'h0},
              {5'd7, 5'd7}, {32'h22, 32'h22}, 1'b1};
    vb[2] = '{2'b00, {5'd0, 5'd0}, {32'h0,  32'h0},
              {5'd0, 5'd7}, {32'h0,  32'h22}, 1'b0};
    vb[3] = '{2'b11, {5'd0, 5'd0}, {32'h22, 32'h11},
              {5'd7, 5'd0}, {32'h22, 32'h0},  1'b0};
    vb[4] = '{2'b00, {5'd0, 5'd0}, {32'h0,  32'h0},
              {5'd7, 5'd0}, {32'h22, 32'h0},  1'b0};
    vb[5] = '{2'b11, {5'd9, 5'd4}, {32'h99, 32'h44},
              {5'd9, 5'd4}, {32'h99, 32'h44}, 1'b0};
    vb[6] = '{2'b00, {5'd0, 5'd0}, {32'h0,  32'h0},
              {5'd9, 5'd4}, {32'h99, 32'h44}, 1'b0};
    vb[7] = '{2'b01, {5'd9, 5'd9}, {32'hBB, 32'hAA},
              {5'd4, 5'd9}, {32'h44, 32'hAA}, 1'b0};
    vb[8] = '{2'b10, {5'd4, 5'd4}, {32'hDD, 32'hCC},
              {5'd9, 5'd4}, {32'hAA, 32'hDD}, 1'b0};
    vb[9] = '{2'b00, {5'd0, 5'd0}, {32'h0,  32'h0},
              {5'd9, 5'd4}, {32'hAA, 32'hDD}, 1'b0};

    a_ra = {5'd5, 5'd3}; a_wa = '0; a_wd = '0; a_we = 1'b0;
    b_ra = '0; b_wa = '0; b_wd = '0; b_we = '0;
    c_ra = '0; c_wa = '0; c_wd = '0; c_we = 1'b0;

    // Reset state
    tick();
    chk("rst_ready_a", 64'(a_rdy), 64'd0);
    chk("rst_wconf_b", 64'(b_wc), 64'd0);
    chk("rst_ready_c", 64'(c_rdy), 64'd0);
    chk("rst_rdata_a", a_rd, 64'd0);
    rst = 1'b0;

    // Sweep: ready latency, writes ignored, reads zero
    for (int k = 1; k <= 32; k++) begin
      if (k == 3) begin
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hCAFE0005;
        a_ra = {5'd0, 5'd5};
        #1;
        chk("init_no_fwd", a_rd, 64'd0);
      end
      tick();
      a_we = 1'b0;
      chk($sformatf("ready_a_k%0d", k), 64'(a_rdy),
          64'(k >= 32));
      chk($sformatf("ready_c_k%0d", k), 64'(c_rdy),
          64'(k >= 8));
    end

    for (int i = 0; i < 8; i++) begin
      a_we = va[i].we; a_wa = va[i].wa;
      a_wd = va[i].wd; a_ra = va[i].ra;
      @(negedge clk);
      chk($sformatf("va%0d", i), a_rd, va[i].exp);
      tick();
    end
    a_we = 1'b0;

    for (int i = 0; i < 10; i++) begin
      b_we = vb[i].we; b_wa = vb[i].wa;
      b_wd = vb[i].wd; b_ra = vb[i].ra;
      @(negedge clk);
      chk($sformatf("vb%0d_rd", i), b_rd, vb[i].exp);
      chk($sformatf("vb%0d_wconf", i), 64'(b_wc),
          64'(vb[i].conf));
      tick();
    end
    b_we = '0;

    // c: r0 is an ordinary register here
    c_we = 1'b1; c_wa = 3'd0; c_wd = 16'h0055;
    c_ra = {3'd1, 3'd1, 3'd1, 3'd0};
    @(negedge clk);
    chk("c_r0_fwd", 64'(c_rd[15:0]), 64'h55);
    tick();
    for (int i = 1; i < 8; i++) begin
      c_wa = 3'(i); c_wd = 16'(16'h1000 + i);
      tick();
    end
    c_we = 1'b0;
    for (int s = 0; s < 2; s++) begin
      logic [63:0] e;
      for (int l = 0; l < 4; l++) begin
        c_ra[l*3 +: 3] = 3'(s*4 + l);
        e[l*16 +: 16] = (s*4 + l == 0) ? 16'h0055 :
                        16'(16'h1000 + s*4 + l);
      end
      #1;
      chk($sformatf("c_lanes_set%0d", s), c_rd, e);
    end
    c_ra = {3'd2, 3'd7, 3'd0, 3'd5};
    #1;
    chk("c_lanes_mix", c_rd,
        {16'h1002, 16'h1007, 16'h0055, 16'h1005});

    // Reset, then reset again mid-sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b1;
    tick();
    chk("mid_ready_a", 64'(a_rdy), 64'd0);
    chk("mid_ready_c", 64'(c_rdy), 64'd0);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("re_ready_a_k%0d", k), 64'(a_rdy),
          64'(k >= 32));
      chk($sformatf("re_ready_c_k%0d", k), 64'(c_rdy),
          64'(k >= 8));
    end
    for (int r = 0; r < 32; r++) begin
      a_ra = {5'(31 - r), 5'(r)};
      #1;
      chk($sformatf("clr_a_r%0d", r), a_rd, 64'd0);
    end
    for (int r = 0; r < 8; r++) begin
      c_ra = {4{3'(r)}};
      #1;
      chk($sformatf("clr_c_r%0d", r), c_rd, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
